// File: rtl/div_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_share_ctrl
//  Purpose  : Shares one iterative 32-bit divider between two requesters
//             (requester 0 = EX stage, requester 1 = auxiliary unit).
//             Grants one requester at a time with round-robin priority,
//             latches its operands and steps the divider through
//             start -> wait -> stop (RELEASE) or cancel (DRAIN).
//             The 64-bit {remainder, quotient} is returned with a one-cycle
//             done pulse to the owning requester.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             reqN_i / reqN_signed_i   request and signed-divide flag (N=0,1)
//             reqN_op1_i / reqN_op2_i  dividend / divisor
//             reqN_annul_i             cancel (pipeline flush)
//             reqN_stall_o             request pending and not completing
//             reqN_done_o              one-cycle completion pulse
//             result_o                 last result {rem, quot}
//             div_*                    divider handshake and operands
//             owner_o                  currently granted requester
//  Revision : 1.0  initial release
// ============================================================================
module div_share_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int RR_INIT      = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_i,
  input  logic        req0_signed_i,
  input  logic [31:0] req0_op1_i,
  input  logic [31:0] req0_op2_i,
  input  logic        req0_annul_i,
  output logic        req0_stall_o,
  output logic        req0_done_o,

  input  logic        req1_i,
  input  logic        req1_signed_i,
  input  logic [31:0] req1_op1_i,
  input  logic [31:0] req1_op2_i,
  input  logic        req1_annul_i,
  output logic        req1_stall_o,
  output logic        req1_done_o,

  output logic [63:0] result_o,

  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,

  output logic        owner_o
);

  // Drain counter only needs to hold DRAIN_CYCLES-1.
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t             state,      state_nxt;
  logic               rr_ptr,     rr_ptr_nxt;
  logic               owner,      owner_nxt;
  logic               start,      start_nxt;
  logic               annul,      annul_nxt;
  logic               sgn,        sgn_nxt;
  logic [31:0]        op1,        op1_nxt;
  logic [31:0]        op2,        op2_nxt;
  logic [63:0]        result,     result_nxt;
  logic               done0,      done0_nxt;
  logic               done1,      done1_nxt;
  logic [CNT_W-1:0]   drain_cnt,  drain_cnt_nxt;

  logic               elig0;
  logic               elig1;
  logic               pick;
  logic               own_req;
  logic               own_annul;
  logic               cancel;

  assign elig0 = req0_i & ~req0_annul_i;
  assign elig1 = req1_i & ~req1_annul_i;

  // With both eligible the priority pointer decides, otherwise the lone one.
  assign pick = (elig0 & elig1) ? rr_ptr : elig1;

  assign own_req   = owner ? req1_i       : req0_i;
  assign own_annul = owner ? req1_annul_i : req0_annul_i;
  // Withdrawal of the owner's request is treated exactly like a flush.
  assign cancel    = own_annul | ~own_req;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= (RR_INIT != 0);
      owner     <= 1'b0;
      start     <= 1'b0;
      annul     <= 1'b0;
      sgn       <= 1'b0;
      op1       <= 32'd0;
      op2       <= 32'd0;
      result    <= 64'd0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      start     <= start_nxt;
      annul     <= annul_nxt;
      sgn       <= sgn_nxt;
      op1       <= op1_nxt;
      op2       <= op2_nxt;
      result    <= result_nxt;
      done0     <= done0_nxt;
      done1     <= done1_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    start_nxt     = start;
    annul_nxt     = annul;
    sgn_nxt       = sgn;
    op1_nxt       = op1;
    op2_nxt       = op2;
    result_nxt    = result;
    done0_nxt     = 1'b0;
    done1_nxt     = 1'b0;
    drain_cnt_nxt = drain_cnt;

    case (state)
      S_IDLE: begin
        if (elig0 | elig1) begin
          owner_nxt  = pick;
          rr_ptr_nxt = ~pick;
          sgn_nxt    = pick ? req1_signed_i : req0_signed_i;
          op1_nxt    = pick ? req1_op1_i    : req0_op1_i;
          op2_nxt    = pick ? req1_op2_i    : req0_op2_i;
          start_nxt  = 1'b1;
          state_nxt  = S_BUSY;
        end
      end

      S_BUSY: begin
        // Cancel has priority over a coincident ready; the result is dropped.
        if (cancel) begin
          start_nxt     = 1'b0;
          annul_nxt     = 1'b1;
          drain_cnt_nxt = CNT_W'(DRAIN_CYCLES - 1);
          state_nxt     = S_DRAIN;
        end else if (div_ready_i) begin
          result_nxt = div_result_i;
          done0_nxt  = ~owner;
          done1_nxt  = owner;
          start_nxt  = 1'b0;
          state_nxt  = S_RELEASE;
        end
      end

      S_RELEASE: begin
        // One cycle with start low lets the divider drop ready before reuse.
        state_nxt = S_IDLE;
      end

      S_DRAIN: begin
        // Divider ready is deliberately ignored while annul is held.
        if (drain_cnt == '0) begin
          annul_nxt = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          drain_cnt_nxt = drain_cnt - CNT_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req0_done_o  = done0;
  assign req1_done_o  = done1;
  assign req0_stall_o = req0_i & ~done0;
  assign req1_stall_o = req1_i & ~done1;
  assign result_o     = result;
  assign div_start_o  = start;
  assign div_annul_o  = annul;
  assign div_signed_o = sgn;
  assign div_op1_o    = op1;
  assign div_op2_o    = op2;
  assign owner_o      = owner;

endmodule
`default_nettype wire
